// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default datapath widths and the NOP encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Default program-counter and instruction widths for the front end.
  localparam int CPU_ADDR_W  = 32;
  localparam int CPU_INSTR_W = 32;

  // Instruction word presented to decode when no valid entry is available.
  localparam logic [31:0] CPU_NOP = 32'h0000_0000;

endpackage

// File: rtl/fq_storage.sv
// Fetch queue entry array: one write port, one asynchronous read port, async clear.
// Latency: write visible on the read port after the write edge; read is combinational.
// Backpressure: none; the caller decides when to write.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the selected entry; reset wipes every entry so no stale data survives.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between instruction fetch and decode (PC + instruction per entry).
// Latency: 1 cycle push-to-pop; 0 cycles on an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
// Backpressure: push_ready = not full (independent of pop_ready); flush blocks push and pop.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     flush,
  input  logic                     push_valid,
  input  logic [ADDR_W-1:0]        push_pc,
  input  logic [INSTR_W-1:0]       push_instr,
  output logic                     push_ready,
  output logic                     pop_valid,
  output logic [ADDR_W-1:0]        pop_pc,
  output logic [INSTR_W-1:0]       pop_instr,
  input  logic                     pop_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + INSTR_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [ENT_W-1:0] rd_ent;
  logic             not_empty;
  logic             bypass;
  logic             do_push;
  logic             do_pop;

  assign not_empty  = (cnt != '0);
  assign push_ready = (cnt != CNT_FULL);
  assign count      = cnt;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue with a consumer waiting: hand the fetched entry straight through.
  assign bypass = !not_empty && push_valid && pop_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry is consumed on the spot and never written into the array.
  assign do_push = push_valid && push_ready && !flush && !bypass;
  assign do_pop  = not_empty && pop_ready && !flush;

  assign pop_valid = (not_empty && !flush) || bypass;

  // Outputs read as zero / NOP whenever nothing valid is presented.
  always_comb begin
    pop_pc    = '0;
    pop_instr = INSTR_W'(CPU_NOP);
    if (bypass) begin
      pop_pc    = push_pc;
      pop_instr = push_instr;
    end else if (pop_valid) begin
      pop_pc    = rd_ent[ENT_W-1:INSTR_W];
      pop_instr = rd_ent[INSTR_W-1:0];
    end
  end

  // Pointer and occupancy tracking; flush returns everything to the empty state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_storage (
    .Clk   (Clk),
    .Rst   (Rst),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata ({push_pc, push_instr}),
    .raddr (rd_ptr),
    .rdata (rd_ent)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=4, 32-bit PC/instruction).
// Latency: scoreboard model predicts outputs one step at a time.
// Backpressure: bench holds refused pushes and randomises pop_ready.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_pc = '0;
  logic [31:0] push_instr = '0;
  logic        push_ready;
  logic        pop_valid;
  logic [31:0] pop_pc;
  logic [31:0] pop_instr;
  logic        pop_ready = 1'b0;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  ent_t sb[$];

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (32),
    .INSTR_W (32)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_pc    (push_pc),
    .push_instr (push_instr),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_pc     (pop_pc),
    .pop_instr  (pop_instr),
    .pop_ready  (pop_ready),
    .count      (count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock step: drive at the falling edge, check outputs against the model,
  // then let the rising edge happen and update the scoreboard.
  task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] instr,
                      input logic pr, input logic fl, output logic acc);
    logic exp_vld;
    logic byp;
    logic mpush;
    logic mpop;
    ent_t head;
    ent_t popped;
    @(negedge Clk);
    push_valid = pv;
    push_pc    = pc;
    push_instr = instr;
    pop_ready  = pr;
    flush      = fl;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sb.size() == 0) && pv && pr && !fl;
`else
    byp = 1'b0;
`endif
    exp_vld = ((sb.size() != 0) && !fl) || byp;
    head    = '0;
    if (byp) head = '{pc: pc, instr: instr};
    else if (exp_vld) head = sb[0];
    chk("count", 64'(count), 64'(sb.size()));
    chk("push_ready", 64'(push_ready), 64'(sb.size() != DEPTH));
    chk("pop_valid", 64'(pop_valid), 64'(exp_vld));
    chk("pop_pc", 64'(pop_pc), 64'(head.pc));
    chk("pop_instr", 64'(pop_instr), 64'(head.instr));
    mpush = pv && (sb.size() != DEPTH) && !fl && !byp;
    mpop  = (sb.size() != 0) && pr && !fl;
    acc   = (pv && (sb.size() != DEPTH) && !fl) || byp;
    @(posedge Clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (mpop) popped = sb.pop_front();
      if (mpush) sb.push_back('{pc: pc, instr: instr});
    end
  endtask

  task automatic idle(input logic pr);
    logic acc;
    step(1'b0, 32'h0, 32'h0, pr, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    logic [31:0] next_pc;

    // Reset state while Rst is held.
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_pop_pc", 64'(pop_pc), 64'd0);
    chk("rst_pop_instr", 64'(pop_instr), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;

    // Two pushes, then drain in order: count 1,2,1,0.
    step(1'b1, 32'h0, 32'h2008_0005, 1'b0, 1'b0, acc);
    step(1'b1, 32'h4, 32'h2009_0003, 1'b0, 1'b0, acc);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Fill to four, fifth push with PC 0x10 refused and then withdrawn.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0, 1'b0, acc);
    step(1'b1, 32'h10, 32'h1000_0004, 1'b0, 1'b0, acc);
    chk("full_refused", 64'(acc), 64'd0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Full queue with push and pop together: 0x10 held until accepted, nothing lost.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 32'h3000_0000 + 32'(i), 1'b0, 1'b0, acc);
    acc = 1'b0;
    for (int t = 0; t < 4 && !acc; t++) step(1'b1, 32'h10, 32'h3000_0004, 1'b1, 1'b0, acc);
    chk("full_push_accepted", 64'(acc), 64'd1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Three entries, flush with a push presented: all discarded.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(i * 4), 32'h5000_0000 + 32'(i), 1'b0, 1'b0, acc);
    step(1'b1, 32'h200, 32'h5555_5555, 1'b1, 1'b1, acc);
    step(1'b1, 32'h50, 32'h0000_0050, 1'b0, 1'b0, acc);
    idle(1'b1);
    idle(1'b0);

    // Rst between clock edges with two entries queued.
    step(1'b1, 32'h60, 32'h0000_0060, 1'b0, 1'b0, acc);
    step(1'b1, 32'h64, 32'h0000_0064, 1'b0, 1'b0, acc);
    @(negedge Clk);
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    #2;
    Rst = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_pop_valid", 64'(pop_valid), 64'd0);
    chk("arst_push_ready", 64'(push_ready), 64'd1);
    chk("arst_pop_pc", 64'(pop_pc), 64'd0);
    chk("arst_pop_instr", 64'(pop_instr), 64'd0);
    sb.delete();
    @(negedge Clk);
    Rst = 1'b0;
    step(1'b1, 32'h40, 32'h0000_0040, 1'b0, 1'b0, acc);
    idle(1'b1);
    idle(1'b0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue, consumer ready: entry passes straight through, count stays 0.
    step(1'b1, 32'h8, 32'h0109_5020, 1'b1, 1'b0, acc);
    idle(1'b0);
`endif

    // Random traffic to exercise pointer wrap, holds and occasional flushes.
    next_pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      logic pv;
      logic pr;
      logic fl;
      pv = 1'($urandom_range(0, 1));
      pr = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 19) == 0);
      step(pv, next_pc, $urandom, pr, fl, acc);
      if (acc && !fl) next_pc = next_pc + 32'd4;
    end
    for (int i = 0; i < 5; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
